// File: rtl/subservient_ram_wide.sv
// Shared SRAM port arbiter: SERV register file plus a 32-bit Wishbone slave on one sync-read SRAM.
// Each Wishbone access becomes 32/sram_dw SRAM beats; RF traffic always wins and stalls the beats.
module subservient_ram_wide #(
  parameter int sram_dw = 8,
  parameter int depth   = 256,
  parameter int aw      = $clog2(depth)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [aw-1:0]                    i_waddr,
  input  logic [sram_dw-1:0]               i_wdata,
  input  logic                             i_wen,
  input  logic [aw-1:0]                    i_raddr,
  input  logic                             i_ren,
  output logic [sram_dw-1:0]               o_rdata,
  output logic [aw-1:0]                    o_sram_waddr,
  output logic [sram_dw-1:0]               o_sram_wdata,
  output logic [sram_dw/8-1:0]             o_sram_wmask,
  output logic                             o_sram_wen,
  output logic [aw-1:0]                    o_sram_raddr,
  input  logic [sram_dw-1:0]               i_sram_rdata,
  input  logic [aw-$clog2(32/sram_dw)-1:0] i_wb_adr,
  input  logic [31:0]                      i_wb_dat,
  input  logic [3:0]                       i_wb_sel,
  input  logic                             i_wb_we,
  input  logic                             i_wb_stb,
  output logic [31:0]                      o_wb_rdt,
  output logic                             o_wb_ack
);
  localparam int NB  = 32 / sram_dw;
  localparam int BW  = $clog2(NB);
  localparam int MW  = sram_dw / 8;
  localparam int BCW = (BW > 0) ? BW : 1;
  localparam logic [BCW-1:0] LAST = BCW'(NB - 1);

  logic               wb_go;
  logic [BCW-1:0]     beat;
  logic [aw-1:0]      wb_addr;
  logic [4:0]         dat_lsb;
  logic [1:0]         sel_lsb;
  logic [sram_dw-1:0] wb_lane_dat;
  logic [MW-1:0]      wb_lane_sel;

  // The ack term idles the sequencer for one cycle so a held stb cannot restart the access.
  assign wb_go   = i_wb_stb & ~i_wen & ~i_ren & ~o_wb_ack;
  assign o_rdata = i_sram_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      beat <= '0;
    end else if (wb_go) begin
      beat <= (beat == LAST) ? '0 : beat + 1'b1;
    end
  end

  generate
    if (NB == 1) begin : g_addr_one
      assign wb_addr = i_wb_adr;
    end else begin : g_addr_multi
      assign wb_addr = {i_wb_adr, beat};
    end
  endgenerate

  assign dat_lsb     = 5'(32'(beat) * sram_dw);
  assign sel_lsb     = 2'(32'(beat) * MW);
  assign wb_lane_dat = i_wb_dat[dat_lsb +: sram_dw];
  assign wb_lane_sel = i_wb_sel[sel_lsb +: MW];

  always_comb begin
    o_sram_waddr = i_waddr;
    o_sram_raddr = i_raddr;
    o_sram_wdata = i_wdata;
    o_sram_wmask = '1;
    o_sram_wen   = i_wen;
    if (wb_go) begin
      o_sram_waddr = wb_addr;
      o_sram_raddr = wb_addr;
      o_sram_wdata = wb_lane_dat;
      o_sram_wmask = wb_lane_sel;
      o_sram_wen   = i_wb_we & (|wb_lane_sel);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_wb_ack <= 1'b0;
    end else begin
      o_wb_ack <= wb_go & (beat == LAST);
    end
  end

  // Lower lanes are captured as they return; the top lane is forwarded live in the ack cycle.
  generate
    if (NB == 1) begin : g_rdt_one
      assign o_wb_rdt = i_sram_rdata;
    end else begin : g_rdt_multi
      logic                rd_v;
      logic [BCW-1:0]      rd_b;
      logic [31-sram_dw:0] wb_rdt;
      logic [4:0]          rd_lsb;

      assign rd_lsb = 5'(32'(rd_b) * sram_dw);

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          rd_v   <= 1'b0;
          rd_b   <= '0;
          wb_rdt <= '0;
        end else begin
          rd_v <= wb_go & ~i_wb_we;
          rd_b <= beat;
          if (rd_v && (rd_b != LAST)) begin
            wb_rdt[rd_lsb +: sram_dw] <= i_sram_rdata;
          end
        end
      end

      assign o_wb_rdt = {i_sram_rdata, wb_rdt};
    end
  endgenerate

endmodule

// File: tb/tb_subservient_ram_wide.sv
// Directed bench for subservient_ram_wide at sram_dw = 8, 16 and 32, each with its own SRAM model.
// Read words are queued when an access starts and checked when the ack appears.
module tb_subservient_ram_wide;
  logic clk;
  logic rst_n;
  logic preload;

  int vectors;
  int miscompares;
  logic [31:0] rdq[$];

  // dw=8 instance signals
  logic [7:0]  waddr8, raddr8, wdata8, rdata8, sw_addr8, sw_data8, sr_addr8, sr_data8;
  logic        wen8, ren8, sw_en8, we8, stb8, ack8;
  logic [0:0]  sw_mask8;
  logic [5:0]  adr8;
  logic [31:0] dat8, rdt8;
  logic [3:0]  sel8;
  // dw=16 instance signals
  logic [7:0]  waddr16, raddr16, sw_addr16, sr_addr16;
  logic [15:0] wdata16, rdata16, sw_data16, sr_data16;
  logic        wen16, ren16, sw_en16, we16, stb16, ack16;
  logic [1:0]  sw_mask16;
  logic [6:0]  adr16;
  logic [31:0] dat16, rdt16;
  logic [3:0]  sel16;
  // dw=32 instance signals
  logic [7:0]  waddr32, raddr32, sw_addr32, sr_addr32;
  logic [31:0] wdata32, rdata32, sw_data32, sr_data32;
  logic        wen32, ren32, sw_en32, we32, stb32, ack32;
  logic [3:0]  sw_mask32;
  logic [7:0]  adr32;
  logic [31:0] dat32, rdt32;
  logic [3:0]  sel32;

  logic [7:0]  m8  [256];
  logic [15:0] m16 [256];
  logic [31:0] m32 [256];

  function automatic logic [7:0]  p8 (int i); return 8'(i * 37 + 5); endfunction
  function automatic logic [15:0] p16(int i); return 16'(i * 1031 + 7); endfunction
  function automatic logic [31:0] p32(int i); return 32'(i * 32'h01010101) ^ 32'hA5A50F0F; endfunction

  subservient_ram_wide #(.sram_dw(8), .depth(256)) u_dw8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_waddr(waddr8), .i_wdata(wdata8), .i_wen(wen8), .i_raddr(raddr8), .i_ren(ren8),
    .o_rdata(rdata8),
    .o_sram_waddr(sw_addr8), .o_sram_wdata(sw_data8), .o_sram_wmask(sw_mask8), .o_sram_wen(sw_en8),
    .o_sram_raddr(sr_addr8), .i_sram_rdata(sr_data8),
    .i_wb_adr(adr8), .i_wb_dat(dat8), .i_wb_sel(sel8), .i_wb_we(we8), .i_wb_stb(stb8),
    .o_wb_rdt(rdt8), .o_wb_ack(ack8)
  );

  subservient_ram_wide #(.sram_dw(16), .depth(256)) u_dw16 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_waddr(waddr16), .i_wdata(wdata16), .i_wen(wen16), .i_raddr(raddr16), .i_ren(ren16),
    .o_rdata(rdata16),
    .o_sram_waddr(sw_addr16), .o_sram_wdata(sw_data16), .o_sram_wmask(sw_mask16), .o_sram_wen(sw_en16),
    .o_sram_raddr(sr_addr16), .i_sram_rdata(sr_data16),
    .i_wb_adr(adr16), .i_wb_dat(dat16), .i_wb_sel(sel16), .i_wb_we(we16), .i_wb_stb(stb16),
    .o_wb_rdt(rdt16), .o_wb_ack(ack16)
  );

  subservient_ram_wide #(.sram_dw(32), .depth(256)) u_dw32 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_waddr(waddr32), .i_wdata(wdata32), .i_wen(wen32), .i_raddr(raddr32), .i_ren(ren32),
    .o_rdata(rdata32),
    .o_sram_waddr(sw_addr32), .o_sram_wdata(sw_data32), .o_sram_wmask(sw_mask32), .o_sram_wen(sw_en32),
    .o_sram_raddr(sr_addr32), .i_sram_rdata(sr_data32),
    .i_wb_adr(adr32), .i_wb_dat(dat32), .i_wb_sel(sel32), .i_wb_we(we32), .i_wb_stb(stb32),
    .o_wb_rdt(rdt32), .o_wb_ack(ack32)
  );

  always #5 clk = ~clk;

  // Sync-read SRAM models with byte masking; read-during-write returns the old word.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) m8[i] <= p8(i);
    end else if (sw_en8 && sw_mask8[0]) begin
      m8[sw_addr8] <= sw_data8;
    end
    sr_data8 <= m8[sr_addr8];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) m16[i] <= p16(i);
    end else if (sw_en16) begin
      for (int b = 0; b < 2; b++)
        if (sw_mask16[b]) m16[sw_addr16][b*8 +: 8] <= sw_data16[b*8 +: 8];
    end
    sr_data16 <= m16[sr_addr16];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) m32[i] <= p32(i);
    end else if (sw_en32) begin
      for (int b = 0; b < 4; b++)
        if (sw_mask32[b]) m32[sw_addr32][b*8 +: 8] <= sw_data32[b*8 +: 8];
    end
    sr_data32 <= m32[sr_addr32];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    if (rdq.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected a queued word, queue empty", tag, obs);
    end else begin
      check_output(tag, obs, rdq.pop_front());
    end
  endtask

  initial begin
    logic [15:0] old16;
    vectors = 0; miscompares = 0;
    clk = 0; rst_n = 0; preload = 1;
    waddr8 = '0; raddr8 = '0; wdata8 = '0; wen8 = 0; ren8 = 0;
    adr8 = '0; dat8 = '0; sel8 = '0; we8 = 0; stb8 = 0;
    waddr16 = '0; raddr16 = '0; wdata16 = '0; wen16 = 0; ren16 = 0;
    adr16 = '0; dat16 = '0; sel16 = '0; we16 = 0; stb16 = 0;
    waddr32 = '0; raddr32 = '0; wdata32 = '0; wen32 = 0; ren32 = 0;
    adr32 = '0; dat32 = '0; sel32 = '0; we32 = 0; stb32 = 0;

    next_cycle();
    preload = 0;
    next_cycle();
    @(negedge clk);
    check_output("rst_ack8", 32'(ack8), 32'd0);
    check_output("rst_ack16", 32'(ack16), 32'd0);
    check_output("rst_ack32", 32'(ack32), 32'd0);
    check_output("rst_rdt8_low", 32'(rdt8[23:0]), 32'd0);
    check_output("rst_rdt16_low", 32'(rdt16[15:0]), 32'd0);
    rst_n = 1;
    next_cycle();

    // dw=8 read of word 5, no RF traffic
    stb8 = 1; adr8 = 6'd5; we8 = 0; sel8 = 4'hF;
    rdq.push_back({m8[23], m8[22], m8[21], m8[20]});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("t1_raddr_c%0d", c), 32'(sr_addr8), 32'(20 + c));
      check_output($sformatf("t1_noack_c%0d", c), 32'(ack8), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check_output("t1_ack", 32'(ack8), 32'd1);
    pop_check("t1_rdt", rdt8);
    next_cycle();
    stb8 = 0;
    @(negedge clk);
    check_output("t1_ack_pulse", 32'(ack8), 32'd0);
    next_cycle();

    // dw=16 write 0xAABBCCDD with only byte 2 selected
    old16 = m16[21];
    stb16 = 1; we16 = 1; adr16 = 7'd10; dat16 = 32'hAABBCCDD; sel16 = 4'b0100;
    @(negedge clk);
    check_output("t2_b0_wen", 32'(sw_en16), 32'd0);
    check_output("t2_b0_addr", 32'(sw_addr16), 32'd20);
    check_output("t2_b0_ack", 32'(ack16), 32'd0);
    next_cycle();
    @(negedge clk);
    check_output("t2_b1_wen", 32'(sw_en16), 32'd1);
    check_output("t2_b1_mask", 32'(sw_mask16), 32'd1);
    check_output("t2_b1_data", 32'(sw_data16), 32'h0000AABB);
    check_output("t2_b1_addr", 32'(sw_addr16), 32'd21);
    next_cycle();
    @(negedge clk);
    check_output("t2_ack", 32'(ack16), 32'd1);
    next_cycle();
    stb16 = 0; we16 = 0;
    @(negedge clk);
    check_output("t2_mem21", 32'(m16[21]), 32'({old16[15:8], 8'hBB}));
    check_output("t2_mem20", 32'(m16[20]), 32'(p16(20)));
    next_cycle();

    // dw=8 read of word 9 with RF read in cycle 1 and RF write in cycle 2
    stb8 = 1; adr8 = 6'd9; we8 = 0; sel8 = 4'hF;
    rdq.push_back({m8[39], m8[38], m8[37], m8[36]});
    @(negedge clk);
    check_output("t3_c0_raddr", 32'(sr_addr8), 32'd36);
    next_cycle();
    ren8 = 1; raddr8 = 8'd100;
    @(negedge clk);
    check_output("t3_c1_rf_raddr", 32'(sr_addr8), 32'd100);
    check_output("t3_c1_wen", 32'(sw_en8), 32'd0);
    next_cycle();
    ren8 = 0; wen8 = 1; waddr8 = 8'd200; wdata8 = 8'h5A;
    @(negedge clk);
    check_output("t3_c2_rf_waddr", 32'(sw_addr8), 32'd200);
    check_output("t3_c2_rf_wen", 32'(sw_en8), 32'd1);
    check_output("t3_c2_rf_wdata", 32'(sw_data8), 32'h5A);
    check_output("t3_c2_rf_wmask", 32'(sw_mask8), 32'd1);
    next_cycle();
    wen8 = 0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("t3_beat%0d_raddr", c), 32'(sr_addr8), 32'(36 + c));
      check_output($sformatf("t3_beat%0d_noack", c), 32'(ack8), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check_output("t3_ack_c6", 32'(ack8), 32'd1);
    pop_check("t3_rdt", rdt8);
    next_cycle();
    stb8 = 0;
    @(negedge clk);
    check_output("t3_mem200", 32'(m8[200]), 32'h5A);
    next_cycle();

    // dw=32 back-to-back reads of words 3 and 77
    stb32 = 1; adr32 = 8'd3; we32 = 0; sel32 = 4'hF;
    rdq.push_back(m32[3]);
    @(negedge clk);
    check_output("t4_a_raddr", 32'(sr_addr32), 32'd3);
    check_output("t4_a_noack", 32'(ack32), 32'd0);
    next_cycle();
    @(negedge clk);
    check_output("t4_a_ack", 32'(ack32), 32'd1);
    pop_check("t4_a_rdt", rdt32);
    next_cycle();
    adr32 = 8'd77;
    rdq.push_back(m32[77]);
    @(negedge clk);
    check_output("t4_b_raddr", 32'(sr_addr32), 32'd77);
    check_output("t4_b_noack", 32'(ack32), 32'd0);
    next_cycle();
    @(negedge clk);
    check_output("t4_b_ack", 32'(ack32), 32'd1);
    pop_check("t4_b_rdt", rdt32);
    next_cycle();
    stb32 = 0;
    @(negedge clk);
    check_output("t4_idle", 32'(ack32), 32'd0);
    next_cycle();

    // dw=8 write of word 12 interrupted by reset in its third cycle, then re-issued
    stb8 = 1; we8 = 1; adr8 = 6'd12; dat8 = 32'h11223344; sel8 = 4'hF;
    @(negedge clk);
    check_output("t5_b0_addr", 32'(sw_addr8), 32'd48);
    check_output("t5_b0_data", 32'(sw_data8), 32'h44);
    check_output("t5_b0_wen", 32'(sw_en8), 32'd1);
    next_cycle();
    @(negedge clk);
    check_output("t5_b1_addr", 32'(sw_addr8), 32'd49);
    check_output("t5_b1_data", 32'(sw_data8), 32'h33);
    next_cycle();
    rst_n = 0; stb8 = 0;
    @(negedge clk);
    check_output("t5_rst_noack", 32'(ack8), 32'd0);
    next_cycle();
    rst_n = 1; stb8 = 1;
    @(negedge clk);
    check_output("t5_post_noack", 32'(ack8), 32'd0);
    check_output("t5_mem48", 32'(m8[48]), 32'h44);
    check_output("t5_mem49", 32'(m8[49]), 32'h33);
    check_output("t5_mem50_kept", 32'(m8[50]), 32'(p8(50)));
    check_output("t5_mem51_kept", 32'(m8[51]), 32'(p8(51)));
    check_output("t5_rdt_cleared", 32'(rdt8[23:0]), 32'd0);
    check_output("t5_reissue_addr0", 32'(sw_addr8), 32'd48);
    next_cycle();
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("t5_reissue_addr%0d", c), 32'(sw_addr8), 32'(48 + c));
      check_output($sformatf("t5_reissue_noack%0d", c), 32'(ack8), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check_output("t5_reissue_ack", 32'(ack8), 32'd1);
    next_cycle();
    stb8 = 0; we8 = 0;
    @(negedge clk);
    check_output("t5_mem50", 32'(m8[50]), 32'h22);
    check_output("t5_mem51", 32'(m8[51]), 32'h11);
    check_output("t5_queue_drained", 32'(rdq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
